// File: rtl/sram_req_bridge_pkg.sv
// Shared types, default address map and the address decoder for the dual-SRAM request bridge.
package sram_pkg;

  localparam int unsigned SRAM_AW_DEF = 20;
  localparam logic [31:0] BASE_LO_DEF = 32'h8000_0000;
  localparam logic [31:0] EXT_LO_DEF  = 32'h8040_0000;

  typedef enum logic [1:0] {OWN_NONE, OWN_INST, OWN_DATA} owner_e;
  typedef enum logic {SLOT_IDLE, SLOT_BUSY} slot_e;
  typedef enum logic [1:0] {CHIP_BASE, CHIP_EXT, CHIP_NONE} chip_e;

  // Window arithmetic is done in 33 bits so a window touching 4 GiB cannot wrap.
  function automatic chip_e decode_chip(input logic [31:0] addr,
                                        input logic [31:0] base_lo,
                                        input logic [31:0] ext_lo,
                                        input int unsigned aw);
    logic [32:0] win;
    logic [32:0] off_base;
    logic [32:0] off_ext;
    win      = 33'd1 << (aw + 32'd2);
    off_base = {1'b0, addr} - {1'b0, base_lo};
    off_ext  = {1'b0, addr} - {1'b0, ext_lo};
    if ((addr >= base_lo) && (off_base < win)) begin
      return CHIP_BASE;
    end else if ((addr >= ext_lo) && (off_ext < win)) begin
      return CHIP_EXT;
    end else begin
      return CHIP_NONE;
    end
  endfunction

endpackage

// File: rtl/sram_req_bridge_slot.sv
// One per SRAM chip: IDLE/BUSY slot FSM with owner tracking, combinational request-pin drive
// in the issue cycle and a capture strobe for the owner in the BUSY cycle.
module sram_req_slot
  import sram_pkg::*;
#(
  parameter int unsigned SRAM_AW = SRAM_AW_DEF
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               grant_inst_i,
  input  logic               grant_data_i,
  input  logic [SRAM_AW-1:0] inst_paddr_i,
  input  logic [SRAM_AW-1:0] data_paddr_i,
  input  logic               data_we_i,
  input  logic [3:0]         data_be_n_i,
  input  logic [31:0]        data_wdata_i,
  output logic               idle_o,
  output logic               cap_inst_o,
  output logic               cap_data_o,
  output logic               ce_n_o,
  output logic               we_n_o,
  output logic [3:0]         be_n_o,
  output logic [SRAM_AW-1:0] paddr_o,
  output logic [31:0]        wdata_o
);

  slot_e  state_q, state_d;
  owner_e owner_q, owner_d;
  logic   go_data_s, go_inst_s;

  assign idle_o     = (state_q == SLOT_IDLE);
  assign go_data_s  = idle_o && grant_data_i && !rst_i;
  assign go_inst_s  = idle_o && grant_inst_i && !grant_data_i && !rst_i;
  assign cap_inst_o = (state_q == SLOT_BUSY) && (owner_q == OWN_INST);
  assign cap_data_o = (state_q == SLOT_BUSY) && (owner_q == OWN_DATA);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= SLOT_IDLE;
      owner_q <= OWN_NONE;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    case (state_q)
      SLOT_IDLE: begin
        if (go_data_s) begin
          state_d = SLOT_BUSY;
          owner_d = OWN_DATA;
        end else if (go_inst_s) begin
          state_d = SLOT_BUSY;
          owner_d = OWN_INST;
        end else begin
          state_d = SLOT_IDLE;
          owner_d = OWN_NONE;
        end
      end
      SLOT_BUSY: begin
        state_d = SLOT_IDLE;
        owner_d = OWN_NONE;
      end
      default: begin
        state_d = SLOT_IDLE;
        owner_d = OWN_NONE;
      end
    endcase
  end

  // Pins are only active in the issue cycle; the controller registers them at its end.
  always_comb begin
    ce_n_o  = 1'b1;
    we_n_o  = 1'b1;
    be_n_o  = 4'hF;
    paddr_o = '0;
    wdata_o = 32'h0;
    if (go_data_s) begin
      ce_n_o  = 1'b0;
      we_n_o  = ~data_we_i;
      be_n_o  = data_we_i ? data_be_n_i : 4'b0000;
      paddr_o = data_paddr_i;
      wdata_o = data_wdata_i;
    end else if (go_inst_s) begin
      ce_n_o  = 1'b0;
      we_n_o  = 1'b1;
      be_n_o  = 4'b0000;
      paddr_o = inst_paddr_i;
      wdata_o = 32'h0;
    end else begin
      ce_n_o  = 1'b1;
    end
  end

endmodule

// File: rtl/sram_req_bridge.sv
// Dual-SRAM initiator bridge: decodes fetch and load/store requests to BASE/EXT SRAM,
// arbitrates per chip (DATA over INST) and returns registered data with a one-cycle ACK.
module sram_req_bridge
  import sram_pkg::*;
#(
  parameter int unsigned SRAM_AW = SRAM_AW_DEF,
  parameter logic [31:0] BASE_LO = BASE_LO_DEF,
  parameter logic [31:0] EXT_LO  = EXT_LO_DEF
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               INST_REQ,
  input  logic [31:0]        INST_ADDR,
  output logic               INST_ACK,
  output logic [31:0]        INST_RDATA,
  input  logic               DATA_REQ,
  input  logic               DATA_WE,
  input  logic [31:0]        DATA_ADDR,
  input  logic [3:0]         DATA_BE_N,
  input  logic [31:0]        DATA_WDATA,
  output logic               DATA_ACK,
  output logic [31:0]        DATA_RDATA,
  output logic               DATA_ERR,
  output logic               BASE_RAM_CE_N_I,
  output logic               BASE_RAM_WE_N_I,
  output logic [3:0]         BASE_RAM_BE_N_I,
  output logic [SRAM_AW-1:0] BASE_RAM_PADDR_I,
  output logic [31:0]        BASE_RAM_WDATA_I,
  input  logic [31:0]        BASE_RAM_RDATA,
  output logic               EXT_RAM_CE_N_I,
  output logic               EXT_RAM_WE_N_I,
  output logic [3:0]         EXT_RAM_BE_N_I,
  output logic [SRAM_AW-1:0] EXT_RAM_PADDR_I,
  output logic [31:0]        EXT_RAM_WDATA_I,
  input  logic [31:0]        EXT_RAM_RDATA
);

  chip_e inst_chip_s, data_chip_s;
  logic  inst_elig_s, data_elig_s;
  logic  base_idle_s, ext_idle_s;
  logic  base_cap_inst_s, base_cap_data_s, ext_cap_inst_s, ext_cap_data_s;
  logic  base_gnt_inst_s, base_gnt_data_s, ext_gnt_inst_s, ext_gnt_data_s;

  logic        inst_ack_q, inst_ack_d;
  logic [31:0] inst_rdata_q, inst_rdata_d;
  logic        data_ack_q, data_ack_d;
  logic        data_err_q, data_err_d;
  logic [31:0] data_rdata_q, data_rdata_d;

  assign inst_chip_s = decode_chip(INST_ADDR, BASE_LO, EXT_LO, SRAM_AW);
  assign data_chip_s = decode_chip(DATA_ADDR, BASE_LO, EXT_LO, SRAM_AW);

  // A port acknowledging this cycle or owning a BUSY slot must not be served again.
  assign inst_elig_s = INST_REQ && !RST && !inst_ack_q && !base_cap_inst_s && !ext_cap_inst_s;
  assign data_elig_s = DATA_REQ && !RST && !data_ack_q && !base_cap_data_s && !ext_cap_data_s;

  assign base_gnt_data_s = data_elig_s && (data_chip_s == CHIP_BASE);
  assign ext_gnt_data_s  = data_elig_s && (data_chip_s == CHIP_EXT);
  assign base_gnt_inst_s = inst_elig_s && (inst_chip_s == CHIP_BASE) && !base_gnt_data_s;
  assign ext_gnt_inst_s  = inst_elig_s && (inst_chip_s == CHIP_EXT) && !ext_gnt_data_s;

  sram_req_slot #(.SRAM_AW(SRAM_AW)) u_base_slot (
    .clk_i        (CLK),
    .rst_i        (RST),
    .grant_inst_i (base_gnt_inst_s),
    .grant_data_i (base_gnt_data_s),
    .inst_paddr_i (INST_ADDR[SRAM_AW+1:2]),
    .data_paddr_i (DATA_ADDR[SRAM_AW+1:2]),
    .data_we_i    (DATA_WE),
    .data_be_n_i  (DATA_BE_N),
    .data_wdata_i (DATA_WDATA),
    .idle_o       (base_idle_s),
    .cap_inst_o   (base_cap_inst_s),
    .cap_data_o   (base_cap_data_s),
    .ce_n_o       (BASE_RAM_CE_N_I),
    .we_n_o       (BASE_RAM_WE_N_I),
    .be_n_o       (BASE_RAM_BE_N_I),
    .paddr_o      (BASE_RAM_PADDR_I),
    .wdata_o      (BASE_RAM_WDATA_I)
  );

  sram_req_slot #(.SRAM_AW(SRAM_AW)) u_ext_slot (
    .clk_i        (CLK),
    .rst_i        (RST),
    .grant_inst_i (ext_gnt_inst_s),
    .grant_data_i (ext_gnt_data_s),
    .inst_paddr_i (INST_ADDR[SRAM_AW+1:2]),
    .data_paddr_i (DATA_ADDR[SRAM_AW+1:2]),
    .data_we_i    (DATA_WE),
    .data_be_n_i  (DATA_BE_N),
    .data_wdata_i (DATA_WDATA),
    .idle_o       (ext_idle_s),
    .cap_inst_o   (ext_cap_inst_s),
    .cap_data_o   (ext_cap_data_s),
    .ce_n_o       (EXT_RAM_CE_N_I),
    .we_n_o       (EXT_RAM_WE_N_I),
    .be_n_o       (EXT_RAM_BE_N_I),
    .paddr_o      (EXT_RAM_PADDR_I),
    .wdata_o      (EXT_RAM_WDATA_I)
  );

  always_comb begin
    inst_ack_d   = 1'b0;
    inst_rdata_d = inst_rdata_q;
    if (base_cap_inst_s) begin
      inst_ack_d   = 1'b1;
      inst_rdata_d = BASE_RAM_RDATA;
    end else if (ext_cap_inst_s) begin
      inst_ack_d   = 1'b1;
      inst_rdata_d = EXT_RAM_RDATA;
    end else if (inst_elig_s && (inst_chip_s == CHIP_NONE)) begin
      inst_ack_d   = 1'b1;
      inst_rdata_d = 32'h0;
    end else begin
      inst_ack_d   = 1'b0;
    end
  end

  // DATA_WE is still held in the BUSY cycle, so it tells stores (no data update) from loads.
  always_comb begin
    data_ack_d   = 1'b0;
    data_err_d   = 1'b0;
    data_rdata_d = data_rdata_q;
    if (base_cap_data_s) begin
      data_ack_d = 1'b1;
      if (!DATA_WE) begin
        data_rdata_d = BASE_RAM_RDATA;
      end else begin
        data_rdata_d = data_rdata_q;
      end
    end else if (ext_cap_data_s) begin
      data_ack_d = 1'b1;
      if (!DATA_WE) begin
        data_rdata_d = EXT_RAM_RDATA;
      end else begin
        data_rdata_d = data_rdata_q;
      end
    end else if (data_elig_s && (data_chip_s == CHIP_NONE)) begin
      data_ack_d = 1'b1;
      data_err_d = 1'b1;
    end else begin
      data_ack_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      inst_ack_q   <= 1'b0;
      inst_rdata_q <= 32'h0;
      data_ack_q   <= 1'b0;
      data_err_q   <= 1'b0;
      data_rdata_q <= 32'h0;
    end else begin
      inst_ack_q   <= inst_ack_d;
      inst_rdata_q <= inst_rdata_d;
      data_ack_q   <= data_ack_d;
      data_err_q   <= data_err_d;
      data_rdata_q <= data_rdata_d;
    end
  end

  assign INST_ACK   = inst_ack_q;
  assign INST_RDATA = inst_rdata_q;
  assign DATA_ACK   = data_ack_q;
  assign DATA_ERR   = data_err_q;
  assign DATA_RDATA = data_rdata_q;

endmodule

// File: tb/tb_sram_req_bridge.sv
// Directed self-checking bench for sram_req_bridge with hand-computed expectations.
module tb_sram_req_bridge;

  logic        CLK = 1'b0;
  logic        RST;
  logic        INST_REQ;
  logic [31:0] INST_ADDR;
  logic        INST_ACK;
  logic [31:0] INST_RDATA;
  logic        DATA_REQ;
  logic        DATA_WE;
  logic [31:0] DATA_ADDR;
  logic [3:0]  DATA_BE_N;
  logic [31:0] DATA_WDATA;
  logic        DATA_ACK;
  logic [31:0] DATA_RDATA;
  logic        DATA_ERR;
  logic        BASE_RAM_CE_N_I, BASE_RAM_WE_N_I;
  logic [3:0]  BASE_RAM_BE_N_I;
  logic [19:0] BASE_RAM_PADDR_I;
  logic [31:0] BASE_RAM_WDATA_I, BASE_RAM_RDATA;
  logic        EXT_RAM_CE_N_I, EXT_RAM_WE_N_I;
  logic [3:0]  EXT_RAM_BE_N_I;
  logic [19:0] EXT_RAM_PADDR_I;
  logic [31:0] EXT_RAM_WDATA_I, EXT_RAM_RDATA;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  sram_req_bridge dut (
    .CLK(CLK), .RST(RST),
    .INST_REQ(INST_REQ), .INST_ADDR(INST_ADDR), .INST_ACK(INST_ACK), .INST_RDATA(INST_RDATA),
    .DATA_REQ(DATA_REQ), .DATA_WE(DATA_WE), .DATA_ADDR(DATA_ADDR), .DATA_BE_N(DATA_BE_N),
    .DATA_WDATA(DATA_WDATA), .DATA_ACK(DATA_ACK), .DATA_RDATA(DATA_RDATA), .DATA_ERR(DATA_ERR),
    .BASE_RAM_CE_N_I(BASE_RAM_CE_N_I), .BASE_RAM_WE_N_I(BASE_RAM_WE_N_I),
    .BASE_RAM_BE_N_I(BASE_RAM_BE_N_I), .BASE_RAM_PADDR_I(BASE_RAM_PADDR_I),
    .BASE_RAM_WDATA_I(BASE_RAM_WDATA_I), .BASE_RAM_RDATA(BASE_RAM_RDATA),
    .EXT_RAM_CE_N_I(EXT_RAM_CE_N_I), .EXT_RAM_WE_N_I(EXT_RAM_WE_N_I),
    .EXT_RAM_BE_N_I(EXT_RAM_BE_N_I), .EXT_RAM_PADDR_I(EXT_RAM_PADDR_I),
    .EXT_RAM_WDATA_I(EXT_RAM_WDATA_I), .EXT_RAM_RDATA(EXT_RAM_RDATA)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  initial begin
    RST = 1'b1; INST_REQ = 1'b0; INST_ADDR = 32'h0;
    DATA_REQ = 1'b0; DATA_WE = 1'b0; DATA_ADDR = 32'h0; DATA_BE_N = 4'hF; DATA_WDATA = 32'h0;
    BASE_RAM_RDATA = 32'h0; EXT_RAM_RDATA = 32'h0;
    tick(); tick();
    // request held during reset must not reach the pins
    INST_REQ = 1'b1; INST_ADDR = 32'h8000_0000; #1;
    chk("rst_base_ce_n", 32'(BASE_RAM_CE_N_I), 32'h1);
    chk("rst_base_be_n", 32'(BASE_RAM_BE_N_I), 32'hF);
    chk("rst_inst_ack", 32'(INST_ACK), 32'h0);
    chk("rst_inst_rdata", INST_RDATA, 32'h0);
    chk("rst_data_rdata", DATA_RDATA, 32'h0);
    INST_REQ = 1'b0;

    // 1. reset mid-access
    tick(); RST = 1'b0;
    DATA_REQ = 1'b1; DATA_WE = 1'b0; DATA_ADDR = 32'h8000_0010; #1;
    chk("t1_issue_ce_n", 32'(BASE_RAM_CE_N_I), 32'h0);
    chk("t1_issue_paddr", 32'(BASE_RAM_PADDR_I), 32'h4);
    chk("t1_issue_we_n", 32'(BASE_RAM_WE_N_I), 32'h1);
    tick(); RST = 1'b1; DATA_REQ = 1'b0; #1;
    chk("t1_rst_ce_n", 32'(BASE_RAM_CE_N_I), 32'h1);
    tick(); #1;
    chk("t1_no_ack_a", 32'(DATA_ACK), 32'h0);
    RST = 1'b0;
    tick(); #1;
    chk("t1_no_ack_b", 32'(DATA_ACK), 32'h0);
    tick(); #1;
    chk("t1_no_ack_c", 32'(DATA_ACK), 32'h0);

    // 2. single fetch
    tick(); INST_REQ = 1'b1; INST_ADDR = 32'h8000_0004; #1;
    chk("t2_ce_n", 32'(BASE_RAM_CE_N_I), 32'h0);
    chk("t2_paddr", 32'(BASE_RAM_PADDR_I), 32'h1);
    chk("t2_we_n", 32'(BASE_RAM_WE_N_I), 32'h1);
    chk("t2_ext_ce_n", 32'(EXT_RAM_CE_N_I), 32'h1);
    tick(); BASE_RAM_RDATA = 32'h2408_0001; #1;
    chk("t2_busy_ce_n", 32'(BASE_RAM_CE_N_I), 32'h1);
    chk("t2_busy_ack", 32'(INST_ACK), 32'h0);
    tick(); #1;
    chk("t2_ack", 32'(INST_ACK), 32'h1);
    chk("t2_rdata", INST_RDATA, 32'h2408_0001);
    chk("t2_ack_ce_n", 32'(BASE_RAM_CE_N_I), 32'h1);
    INST_REQ = 1'b0;
    tick(); #1;
    chk("t2_ack_pulse", 32'(INST_ACK), 32'h0);

    // 3. store then load to EXT
    DATA_REQ = 1'b1; DATA_WE = 1'b1; DATA_ADDR = 32'h8040_0008;
    DATA_BE_N = 4'b1100; DATA_WDATA = 32'hDEAD_BEEF; #1;
    chk("t3_st_ce_n", 32'(EXT_RAM_CE_N_I), 32'h0);
    chk("t3_st_we_n", 32'(EXT_RAM_WE_N_I), 32'h0);
    chk("t3_st_paddr", 32'(EXT_RAM_PADDR_I), 32'h2);
    chk("t3_st_be_n", 32'(EXT_RAM_BE_N_I), 32'hC);
    chk("t3_st_wdata", EXT_RAM_WDATA_I, 32'hDEAD_BEEF);
    chk("t3_st_base_idle", 32'(BASE_RAM_CE_N_I), 32'h1);
    tick(); EXT_RAM_RDATA = 32'h1111_2222; #1;
    chk("t3_st_busy_ce_n", 32'(EXT_RAM_CE_N_I), 32'h1);
    tick(); #1;
    chk("t3_st_ack", 32'(DATA_ACK), 32'h1);
    chk("t3_st_err", 32'(DATA_ERR), 32'h0);
    chk("t3_st_rdata_kept", DATA_RDATA, 32'h0);
    DATA_WE = 1'b0; #1;
    chk("t3_no_regrant", 32'(EXT_RAM_CE_N_I), 32'h1);
    tick(); #1;
    chk("t3_ld_ce_n", 32'(EXT_RAM_CE_N_I), 32'h0);
    chk("t3_ld_we_n", 32'(EXT_RAM_WE_N_I), 32'h1);
    chk("t3_ld_be_n", 32'(EXT_RAM_BE_N_I), 32'h0);
    chk("t3_ld_paddr", 32'(EXT_RAM_PADDR_I), 32'h2);
    tick(); EXT_RAM_RDATA = 32'hDEAD_BEEF;
    tick(); #1;
    chk("t3_ld_ack", 32'(DATA_ACK), 32'h1);
    chk("t3_ld_rdata", DATA_RDATA, 32'hDEAD_BEEF);
    DATA_REQ = 1'b0;

    // 4. same-chip conflict: DATA first, INST two cycles later
    tick();
    INST_REQ = 1'b1; INST_ADDR = 32'h8000_0000;
    DATA_REQ = 1'b1; DATA_WE = 1'b0; DATA_ADDR = 32'h8000_0100; #1;
    chk("t4_ce_n", 32'(BASE_RAM_CE_N_I), 32'h0);
    chk("t4_paddr_data", 32'(BASE_RAM_PADDR_I), 32'h40);
    tick(); BASE_RAM_RDATA = 32'hAAAA_0001; #1;
    chk("t4_busy_ce_n", 32'(BASE_RAM_CE_N_I), 32'h1);
    chk("t4_inst_ack_early", 32'(INST_ACK), 32'h0);
    tick(); DATA_REQ = 1'b0; #1;
    chk("t4_data_ack", 32'(DATA_ACK), 32'h1);
    chk("t4_data_rdata", DATA_RDATA, 32'hAAAA_0001);
    chk("t4_inst_ce_n", 32'(BASE_RAM_CE_N_I), 32'h0);
    chk("t4_inst_paddr", 32'(BASE_RAM_PADDR_I), 32'h0);
    tick(); BASE_RAM_RDATA = 32'hBBBB_0002; #1;
    chk("t4_inst_wait", 32'(INST_ACK), 32'h0);
    chk("t4_data_pulse", 32'(DATA_ACK), 32'h0);
    tick(); #1;
    chk("t4_inst_ack", 32'(INST_ACK), 32'h1);
    chk("t4_inst_rdata", INST_RDATA, 32'hBBBB_0002);
    INST_REQ = 1'b0;

    // 5. parallel chips
    tick();
    INST_REQ = 1'b1; INST_ADDR = 32'h8000_0000;
    DATA_REQ = 1'b1; DATA_WE = 1'b0; DATA_ADDR = 32'h8040_0000; #1;
    chk("t5_base_ce_n", 32'(BASE_RAM_CE_N_I), 32'h0);
    chk("t5_ext_ce_n", 32'(EXT_RAM_CE_N_I), 32'h0);
    chk("t5_ext_paddr", 32'(EXT_RAM_PADDR_I), 32'h0);
    tick(); BASE_RAM_RDATA = 32'h0000_1234; EXT_RAM_RDATA = 32'h0000_5678;
    tick(); #1;
    chk("t5_inst_ack", 32'(INST_ACK), 32'h1);
    chk("t5_data_ack", 32'(DATA_ACK), 32'h1);
    chk("t5_inst_rdata", INST_RDATA, 32'h0000_1234);
    chk("t5_data_rdata", DATA_RDATA, 32'h0000_5678);
    INST_REQ = 1'b0; DATA_REQ = 1'b0;

    // 6. unmapped data load
    tick();
    DATA_REQ = 1'b1; DATA_WE = 1'b0; DATA_ADDR = 32'h1FC0_0000; #1;
    chk("t6_base_ce_n", 32'(BASE_RAM_CE_N_I), 32'h1);
    chk("t6_ext_ce_n", 32'(EXT_RAM_CE_N_I), 32'h1);
    tick(); #1;
    chk("t6_ack", 32'(DATA_ACK), 32'h1);
    chk("t6_err", 32'(DATA_ERR), 32'h1);
    chk("t6_rdata_kept", DATA_RDATA, 32'h0000_5678);
    chk("t6_ack_ce_n", 32'(BASE_RAM_CE_N_I) | 32'(EXT_RAM_CE_N_I), 32'h1);
    DATA_REQ = 1'b0;
    tick(); #1;
    chk("t6_err_pulse", 32'(DATA_ERR), 32'h0);

    // boundaries: last BASE word, first address past EXT window
    INST_REQ = 1'b1; INST_ADDR = 32'h803F_FFFC; #1;
    chk("b_last_base_ce_n", 32'(BASE_RAM_CE_N_I), 32'h0);
    chk("b_last_base_paddr", 32'(BASE_RAM_PADDR_I), 32'h000F_FFFF);
    tick(); BASE_RAM_RDATA = 32'hCAFE_0003;
    tick(); #1;
    chk("b_last_base_rdata", INST_RDATA, 32'hCAFE_0003);
    INST_ADDR = 32'h8080_0000;
    tick(); #1;
    chk("b_unmap_ce_n", 32'(BASE_RAM_CE_N_I) & 32'(EXT_RAM_CE_N_I), 32'h1);
    tick(); #1;
    chk("b_unmap_inst_ack", 32'(INST_ACK), 32'h1);
    chk("b_unmap_inst_rdata", INST_RDATA, 32'h0);
    INST_REQ = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
